// File: rtl/gray_counter_if.sv
// Bus bundle for the Gray counter: control strobes in, binary/Gray/terminal-count out.
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             tc;

    modport master (
        output en, up, sat, load, load_bin,
        input  bin, gray, tc
    );

    modport slave (
        input  en, up, sat, load, load_bin,
        output bin, gray, tc
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code image, wrap or saturate at the ends,
// synchronous load and a one-cycle terminal-count pulse on every boundary step.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    gray_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             tc_q;
    logic             tc_d;

    // Next-state: load beats enable; a step at an end either wraps or holds, and always raises tc.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                if (bin_q == MAX) begin
                    tc_d  = 1'b1;
                    bin_d = bus.sat ? bin_q : ZERO;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == ZERO) begin
                    tc_d  = 1'b1;
                    bin_d = bus.sat ? bin_q : MAX;
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end else begin
            bin_d = bin_q;
        end
        // Gray is derived from the next binary value so both flops always agree.
        gray_d = bin_to_gray(bin_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= ZERO;
            gray_q <= ZERO;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.gray = gray_q;
    assign bus.tc   = tc_q;

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and code width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  count enable; 1 = take one step this cycle.
REQ-005 Port: up  input  1  direction; 1 = increment, 0 = decrement; sampled only when en=1.
REQ-006 Port: sat  input  1  boundary mode; 1 = saturate at the end value, 0 = wrap around.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_bin  input  WIDTH  binary value taken when load=1.
REQ-009 Port: bin  output  WIDTH  registered binary count state.
REQ-010 Port: gray  output  WIDTH  registered Gray code of the count; this port drives the downstream Gray-to-binary stage.
REQ-011 Port: tc  output  1  registered one-cycle terminal-count pulse.

Function
REQ-012 Every output shall be driven directly from a flop, with no combinational path from any input to any output.
REQ-013 gray shall equal bin ^ (bin >> 1) in every cycle, including after reset and after a load.
REQ-014 Priority per edge: load, then en, then hold.
REQ-015 When load=1, bin shall take load_bin, gray shall take its Gray encoding, and tc shall be 0 on that edge, regardless of en, up or sat.
REQ-016 When load=0 and en=0, bin and gray shall hold and tc shall be 0.
REQ-017 When load=0, en=1 and up=1 with bin below 2^WIDTH-1, bin shall increment by 1 and tc shall be 0.
REQ-018 When load=0, en=1 and up=0 with bin above 0, bin shall decrement by 1 and tc shall be 0.
REQ-019 Up step at bin=2^WIDTH-1: if sat=0, bin shall wrap to 0 with tc=1; if sat=1, bin shall hold with tc=1.
REQ-020 Down step at bin=0: if sat=0, bin shall wrap to 2^WIDTH-1 with tc=1; if sat=1, bin shall hold with tc=1.
REQ-021 Latency from a sampled en or load to updated outputs shall be exactly one clock edge.
REQ-022 tc shall be high only in the cycle following a boundary step; consecutive boundary steps shall keep tc high for each such cycle.
REQ-023 Any two consecutive gray values produced by a single step shall differ in exactly one bit, including across a wrap; a load carries no such guarantee.
REQ-024 Changes to up or sat between cycles shall take effect on the next edge, with no extra delay and no lost steps.
REQ-025 All arithmetic shall be modulo 2^WIDTH, with no wider intermediate state visible at the outputs.

Reset
REQ-026 While rst_n=0, bin, gray and tc shall be 0 immediately, without waiting for a clock edge.
REQ-027 Reset asserted mid-count shall discard the in-progress step.
REQ-028 After rst_n deasserts, the first step shall start from 0.
REQ-029 Inputs shall be ignored while rst_n=0.

Verification
REQ-030 Reset check: hold rst_n=0 with en=1 and toggling clk -> bin=0, gray=0, tc=0 throughout.
REQ-031 Wrap-up check: WIDTH=4, en=1, up=1, sat=0, 16 edges from 0.
  - gray shall step 0001, 0011, 0010, 0110, ..., 1000, then 0000 on the 16th edge with tc=1 only in that cycle.
  - Every transition shall have Hamming distance 1.
REQ-032 Load check: load=1 with load_bin=1010 and en=1 on the same edge -> bin=1010, gray=1111, tc=0; the step shall be ignored.
REQ-033 Saturate check: from bin=1110 with up=1 and sat=1, two steps.
  - First step: bin=1111, gray=1000, tc=0.
  - Second step: bin=1111 held, tc=1.
REQ-034 Wrap-down check: from bin=0000 with up=0 and sat=0, one step -> bin=1111, gray=1000, tc=1; the next step gives bin=1110, gray=1001, tc=0.
REQ-035 Async reset check: pulse rst_n low between clock edges while counting at bin=0101 -> outputs go to 0 before the next edge, and counting resumes 0001, 0010 after release.
